uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer sitting directly downstream of the UART receiver.

---
 rtl/uart_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures one byte per UART rx_done_tick strobe into a circular FIFO and streams it out show-ahead over valid/ready.
// Push in cycle N is visible in N+1; a full FIFO drops the byte unless the head pops that cycle. UART_RX_FIFO_DROPCNT_EN adds drop_count.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_done_tick,
   input  logic [DATA_W-1:0]      din,
   output logic                   m_valid,
   output logic [DATA_W-1:0]      m_data,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   input  logic                   clr_overflow
`ifdef UART_RX_FIFO_DROPCNT_EN
   ,
   output logic [15:0]            drop_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      WAIT_RISE = 1'b0,
      WAIT_FALL = 1'b1
   } wr_state_t;

   wr_state_t         r_state;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_count;
   logic              r_overflow;

   logic              w_push;
   logic              w_pop;
   logic              w_wr_en;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;
   logic [AW-1:0]     w_wr_addr;
   logic [AW-1:0]     w_rd_addr;

   assign w_wr_addr = r_wr_ptr[AW-1:0];
   assign w_rd_addr = r_rd_ptr[AW-1:0];

   // Same low address with differing wrap bit means the writer is a full lap ahead.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_addr == w_rd_addr);

   assign w_push  = (r_state == WAIT_RISE) && rx_done_tick;
   assign w_pop   = !w_empty && m_ready;
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   assign m_valid  = !w_empty;
   assign m_data   = r_mem[w_rd_addr];
   assign count    = r_count;
   assign full     = w_full;
   assign empty    = w_empty;
   assign overflow = r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= WAIT_RISE;
      end else begin
         case (r_state)
            WAIT_RISE: if (rx_done_tick)  r_state <= WAIT_FALL;
            WAIT_FALL: if (!rx_done_tick) r_state <= WAIT_RISE;
            default:                      r_state <= WAIT_RISE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[w_wr_addr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + PW'(1);
            2'b01:   r_count <= r_count - PW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A fresh drop outranks a same-cycle clear so no loss goes unreported.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_DROPCNT_EN
   logic [15:0] r_drop_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_count <= '0;
      end else if (w_drop) begin
         if (clr_overflow) begin
            r_drop_count <= 16'd1;
         end else if (r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
      end else if (clr_overflow) begin
         r_drop_count <= '0;
      end
   end

   assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: fixed vector table, directed corner sequences and a randomized run against a queue model.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_done_tick;
   logic [7:0] din;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       clr_overflow;
`ifdef UART_RX_FIFO_DROPCNT_EN
   logic [15:0] drop_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_done_tick (rx_done_tick),
      .din          (din),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
`ifdef UART_RX_FIFO_DROPCNT_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: a byte queue plus sticky flags.
   logic [7:0] mq[$];
   logic [7:0] got[$];
   bit         m_prev;
   bit         m_ov;
   int         m_drop;
   int         maxc;

   task automatic cycle(input bit r, input bit t, input logic [7:0] d, input bit rdy, input bit clr);
      bit push, pop, drop;
      rst = r; rx_done_tick = t; din = d; m_ready = rdy; clr_overflow = clr;
      if (r) begin
         mq.delete(); m_prev = 0; m_ov = 0; m_drop = 0;
      end else begin
         push   = t && !m_prev;
         m_prev = t;
         pop    = rdy && (mq.size() > 0);
         drop   = push && (mq.size() == DEPTH) && !pop;
         if (pop) begin
            check("pop_data", int'(m_data), int'(mq[0]));
            got.push_back(mq.pop_front());
         end
         if (push && !drop) mq.push_back(d);
         if (drop) begin
            m_ov   = 1;
            m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : m_drop);
         end else if (clr) begin
            m_ov = 0; m_drop = 0;
         end
      end
      @(posedge clk); #1;
      if (int'(count) > maxc) maxc = int'(count);
      check("count", int'(count), mq.size());
      check("m_valid", int'(m_valid), int'(mq.size() > 0));
      check("empty", int'(empty), int'(mq.size() == 0));
      check("full", int'(full), int'(mq.size() == DEPTH));
      check("overflow", int'(overflow), int'(m_ov));
      if (mq.size() > 0) check("m_data", int'(m_data), int'(mq[0]));
`ifdef UART_RX_FIFO_DROPCNT_EN
      check("drop_count", int'(drop_count), m_drop);
`endif
   endtask

   task automatic pulse(input logic [7:0] d);
      cycle(0, 1, d, 0, 0);
      cycle(0, 0, d, 0, 0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 1, 0);
   endtask

   typedef struct {
      bit         rst;
      bit         tick;
      logic [7:0] din;
      bit         rdy;
      bit         clr;
      int         e_cnt;
      bit         e_vld;
      logic [7:0] e_dat;
      bit         chk_dat;
   } vec_t;

   vec_t       tbl[12];
   logic [7:0] sent[$];
   int         pushes;
   bit         t;
   bit         rdy;
   logic [7:0] dd;

   initial begin
      rst = 1; rx_done_tick = 0; din = 0; m_ready = 0; clr_overflow = 0;
      maxc = 0;

      tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1};
      tbl[1]  = '{0, 1, 8'hA5, 0, 0, 1, 1, 8'hA5, 1};
      tbl[2]  = '{0, 1, 8'hA5, 0, 0, 1, 1, 8'hA5, 1};
      tbl[3]  = '{0, 1, 8'hA5, 0, 0, 1, 1, 8'hA5, 1};
      tbl[4]  = '{0, 0, 8'h00, 0, 0, 1, 1, 8'hA5, 1};
      tbl[5]  = '{0, 1, 8'h3C, 0, 0, 2, 1, 8'hA5, 1};
      tbl[6]  = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h3C, 1};
      tbl[7]  = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
      tbl[8]  = '{0, 1, 8'h77, 1, 0, 1, 1, 8'h77, 1};
      tbl[9]  = '{0, 0, 8'h00, 0, 0, 1, 1, 8'h77, 1};
      tbl[10] = '{0, 0, 8'h00, 0, 1, 1, 1, 8'h77, 1};
      tbl[11] = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1};

      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; rx_done_tick = tbl[i].tick; din = tbl[i].din;
         m_ready = tbl[i].rdy; clr_overflow = tbl[i].clr;
         @(posedge clk); #1;
         check($sformatf("vec%0d_count", i), int'(count), tbl[i].e_cnt);
         check($sformatf("vec%0d_valid", i), int'(m_valid), int'(tbl[i].e_vld));
         check($sformatf("vec%0d_empty", i), int'(empty), int'(tbl[i].e_cnt == 0));
         check($sformatf("vec%0d_ovf", i), int'(overflow), 0);
         if (tbl[i].chk_dat) check($sformatf("vec%0d_data", i), int'(m_data), int'(tbl[i].e_dat));
      end

      // Long strobe yields a single entry.
      cycle(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 8'hA5, 0, 0);
      check("t2_count", int'(count), 1);
      check("t2_data", int'(m_data), 8'hA5);
      cycle(0, 0, 8'h00, 0, 0);
      drain(2);

      // Fill, overflow, drain order.
      cycle(1, 0, 8'h00, 0, 0);
      for (int i = 1; i <= 16; i++) pulse(8'(i));
      check("t3_full", int'(full), 1);
      check("t3_count", int'(count), 16);
      pulse(8'h11);
      check("t3_ovf", int'(overflow), 1);
`ifdef UART_RX_FIFO_DROPCNT_EN
      check("t3_dropcnt", int'(drop_count), 1);
`endif
      got.delete();
      drain(17);
      check("t3_ndrained", got.size(), 16);
      for (int i = 0; i < 16; i++) check($sformatf("t3_order%0d", i), int'(got[i]), i + 1);

      // Push into a full FIFO while the head pops; then set-wins on clear.
      cycle(0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 16; i++) pulse(8'(8'h20 + i));
      cycle(0, 1, 8'h55, 1, 0);
      check("t4_count", int'(count), 16);
      check("t4_ovf", int'(overflow), 0);
      cycle(0, 0, 8'h00, 0, 0);
      cycle(0, 1, 8'h66, 0, 1);
      check("t4_setwins", int'(overflow), 1);
`ifdef UART_RX_FIFO_DROPCNT_EN
      check("t4_dropcnt", int'(drop_count), 1);
`endif
      cycle(0, 0, 8'h00, 0, 1);
      got.delete();
      drain(17);
      check("t4_n", got.size(), 16);
      check("t4_first", int'(got[0]), 8'h21);
      check("t4_last", int'(got[15]), 8'h55);

      // Randomized wrap traffic.
      cycle(1, 0, 8'h00, 0, 0);
      got.delete(); sent.delete();
      pushes = 0; t = 0; dd = 0; maxc = 0;
      for (int c = 0; c < 3000 && (pushes < 40 || mq.size() > 0); c++) begin
         rdy = 1'($urandom_range(0, 1));
         if (t) begin
            t = ($urandom_range(0, 2) == 0);
         end else if (pushes < 40 && mq.size() < 14 && $urandom_range(0, 1) == 1) begin
            t = 1; dd = 8'($urandom); pushes++; sent.push_back(dd);
         end
         cycle(0, t, dd, rdy, 0);
      end
      check("t5_pushes", pushes, 40);
      check("t5_ndrained", got.size(), 40);
      for (int i = 0; i < 40 && i < got.size(); i++) check($sformatf("t5_order%0d", i), int'(got[i]), int'(sent[i]));
      check("t5_max_le16", int'(maxc > 16), 0);
      check("t5_ovf", int'(overflow), 0);

      // Reset during a strobe; the strobe still high at release counts as new.
      cycle(1, 0, 8'h00, 0, 0);
      pulse(8'h11); pulse(8'h22); pulse(8'h33);
      cycle(1, 1, 8'hBB, 0, 0);
      check("t6_count", int'(count), 0);
      check("t6_valid", int'(m_valid), 0);
      got.delete();
      cycle(0, 1, 8'hBB, 0, 0);
      cycle(0, 0, 8'h00, 0, 0);
      drain(3);
      check("t6_n", got.size(), 1);
      if (got.size() > 0) check("t6_byte", int'(got[0]), 8'hBB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
